// File: rtl/netwalk_tcam_pkg.sv
// -----------------------------------------------------------------------------
// netwalk_tcam_pkg
// Shared definitions for the netwalk pipelined TCAM: the command opcode width
// and the command opcode encoding. This package has no ports.
// -----------------------------------------------------------------------------
package netwalk_tcam_pkg;

    localparam int CMD_OP_WIDTH = 2;

    typedef enum logic [CMD_OP_WIDTH-1:0] {
        NW_TCAM_OP_WRITE  = 2'b00,
        NW_TCAM_OP_DELETE = 2'b01,
        NW_TCAM_OP_FLUSH  = 2'b10,
        NW_TCAM_OP_RSVD   = 2'b11   // accepted, no effect
    } nw_tcam_op_e;

endpackage

// File: rtl/netwalk_tcam_pipe_if.sv
// -----------------------------------------------------------------------------
// netwalk_tcam_pipe_if
// Bundles the three handshaked streams of the TCAM:
//   lookup   : lkp_valid, lkp_ready, lkp_key, lkp_tag
//   response : rsp_valid, rsp_ready, rsp_hit, rsp_addr, rsp_tag
//   command  : cmd_valid, cmd_ready, cmd_op, cmd_addr, cmd_data, cmd_mask
// Modports: master = client side (parser/control plane), slave = the TCAM.
// -----------------------------------------------------------------------------
interface netwalk_tcam_pipe_if #(
    parameter int KEY_WIDTH       = 356,
    parameter int TCAM_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH       = 5
);
    import netwalk_tcam_pkg::*;

    logic                       lkp_valid;
    logic                       lkp_ready;
    logic [KEY_WIDTH-1:0]       lkp_key;
    logic [TAG_WIDTH-1:0]       lkp_tag;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_hit;
    logic [TCAM_ADDR_WIDTH-1:0] rsp_addr;
    logic [TAG_WIDTH-1:0]       rsp_tag;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [CMD_OP_WIDTH-1:0]    cmd_op;
    logic [TCAM_ADDR_WIDTH-1:0] cmd_addr;
    logic [KEY_WIDTH-1:0]       cmd_data;
    logic [KEY_WIDTH-1:0]       cmd_mask;

    modport master (
        output lkp_valid, lkp_key, lkp_tag, rsp_ready,
               cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        input  lkp_ready, rsp_valid, rsp_hit, rsp_addr, rsp_tag, cmd_ready
    );

    modport slave (
        input  lkp_valid, lkp_key, lkp_tag, rsp_ready,
               cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        output lkp_ready, rsp_valid, rsp_hit, rsp_addr, rsp_tag, cmd_ready
    );

endinterface

// File: rtl/netwalk_prio_encoder.sv
// -----------------------------------------------------------------------------
// netwalk_prio_encoder
// Combinational priority encoder: returns the lowest set index of a multi-hot
// request vector plus an any-bit-set flag.
//   req  in   IN_WIDTH   request vector
//   idx  out  IDX_WIDTH  lowest set index, 0 when req is all-zero
//   hit  out  1          |req
// -----------------------------------------------------------------------------
module netwalk_prio_encoder #(
    parameter  int IN_WIDTH  = 64,
    localparam int IDX_WIDTH = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1
) (
    input  logic [IN_WIDTH-1:0]  req,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 hit
);

    // NOTE: every output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        idx = '0;
        hit = |req;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/netwalk_tcam_pipe.sv
// -----------------------------------------------------------------------------
// netwalk_tcam_pipe
// Pipelined ternary flow-match table. Keys arrive on the lookup stream, the
// lowest matching entry index is returned with the originating tag on the
// response stream. Entries are written / deleted / flushed via the command
// stream. Two register stages: S1 = match vector, S2 = encoded response.
//   clk          in   clock
//   reset        in   synchronous reset, active-low
//   bus          slave modport of netwalk_tcam_pipe_if (lookup/response/command)
//   cnt_rd_addr  in   hit-counter read index
//   cnt_rd_data  out  hit counter of cnt_rd_addr (combinational), 0 when
//                     counters are not built
// Optional feature: define NETWALK_TCAM_HIT_CNT_EN to build per-entry
// saturating hit counters.
// -----------------------------------------------------------------------------
module netwalk_tcam_pipe
    import netwalk_tcam_pkg::*;
#(
    parameter int KEY_WIDTH       = 356,
    parameter int TCAM_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH       = 5,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    netwalk_tcam_pipe_if.slave         bus,
    input  logic [TCAM_ADDR_WIDTH-1:0] cnt_rd_addr,
    output logic [CNT_WIDTH-1:0]       cnt_rd_data
);

    localparam int TCAM_SIZE = 1 << TCAM_ADDR_WIDTH;

    // Both stages move together; they freeze only while a response is stalled.
    logic        adv;
    logic        lkp_fire;
    logic        cmd_fire;
    nw_tcam_op_e cmd_op;

    assign adv           = !bus.rsp_valid || bus.rsp_ready;
    assign bus.cmd_ready = 1'b1;
    // A command owns the cycle, so a lookup never sees a half-updated table.
    assign bus.lkp_ready = adv && !bus.cmd_valid;
    assign lkp_fire      = bus.lkp_valid && bus.lkp_ready;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign cmd_op        = nw_tcam_op_e'(bus.cmd_op);

    // ---------------- entry table ----------------
    logic [TCAM_SIZE-1:0] entry_valid;
    logic [KEY_WIDTH-1:0] entry_data [TCAM_SIZE];
    logic [KEY_WIDTH-1:0] entry_mask [TCAM_SIZE];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_valid <= '0;
        end else if (cmd_fire) begin
            case (cmd_op)
                NW_TCAM_OP_WRITE:  entry_valid[bus.cmd_addr] <= 1'b1;
                NW_TCAM_OP_DELETE: entry_valid[bus.cmd_addr] <= 1'b0;
                NW_TCAM_OP_FLUSH:  entry_valid               <= '0;
                default:           ;
            endcase
        end
    end

    // NOTE: data/mask storage is deliberately not reset; an entry only takes
    // part in matching once its valid bit is set by a WRITE.
    always_ff @(posedge clk) begin
        if (cmd_fire && cmd_op == NW_TCAM_OP_WRITE) begin
            entry_data[bus.cmd_addr] <= bus.cmd_data;
            entry_mask[bus.cmd_addr] <= bus.cmd_mask;
        end
    end

    // ---------------- match (feeds S1) ----------------
    logic [TCAM_SIZE-1:0] match_vec;

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < TCAM_SIZE; i++) begin
            match_vec[i] = entry_valid[i] &&
                           (((bus.lkp_key ^ entry_data[i]) & entry_mask[i]) == '0);
        end
    end

    // ---------------- S1 ----------------
    logic                 s1_valid;
    logic [TCAM_SIZE-1:0] s1_match;
    logic [TAG_WIDTH-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= lkp_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && lkp_fire) begin
            s1_match <= match_vec;
            s1_tag   <= bus.lkp_tag;
        end
    end

    // ---------------- S2 ----------------
    logic [TCAM_ADDR_WIDTH-1:0] enc_addr;
    logic                       enc_hit;

    netwalk_prio_encoder #(
        .IN_WIDTH (TCAM_SIZE)
    ) u_prio_encoder (
        .req (s1_match),
        .idx (enc_addr),
        .hit (enc_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_addr  <= '0;
            bus.rsp_tag   <= '0;
        end else if (adv) begin
            bus.rsp_valid <= s1_valid;
            if (s1_valid) begin
                bus.rsp_hit  <= enc_hit;
                bus.rsp_addr <= enc_addr;   // encoder yields 0 on a miss
                bus.rsp_tag  <= s1_tag;
            end
        end
    end

    // ---------------- hit counters ----------------
`ifdef NETWALK_TCAM_HIT_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] hit_cnt [TCAM_SIZE];
    logic [TCAM_SIZE-1:0] cnt_clr;
    logic                 rsp_hit_fire;

    assign rsp_hit_fire = bus.rsp_valid && bus.rsp_ready && bus.rsp_hit;

    always_comb begin
        cnt_clr = '0;
        if (cmd_fire) begin
            case (cmd_op)
                NW_TCAM_OP_WRITE,
                NW_TCAM_OP_DELETE: cnt_clr[bus.cmd_addr] = 1'b1;
                NW_TCAM_OP_FLUSH:  cnt_clr               = '1;
                default:           ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TCAM_SIZE; i++) hit_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < TCAM_SIZE; i++) begin
                // Clear has priority over a same-cycle increment.
                if (cnt_clr[i]) begin
                    hit_cnt[i] <= '0;
                end else if (rsp_hit_fire && bus.rsp_addr == TCAM_ADDR_WIDTH'(i) &&
                             hit_cnt[i] != CNT_MAX) begin
                    hit_cnt[i] <= hit_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign cnt_rd_data = hit_cnt[cnt_rd_addr];
`else
    logic unused_cnt_rd_addr;

    assign unused_cnt_rd_addr = ^cnt_rd_addr;
    assign cnt_rd_data        = '0;
`endif

endmodule

// File: tb/tb_netwalk_tcam_pipe.sv
// -----------------------------------------------------------------------------
// tb_netwalk_tcam_pipe
// Self-checking bench for netwalk_tcam_pipe. A table/queue model predicts each
// response from the match rule at the moment a lookup handshakes; a negedge
// monitor compares every response handshake and the stall-hold behaviour.
// Directed phases pin literal values; a random phase follows.
// With NETWALK_TCAM_HIT_CNT_EN the counters are built 2 bits wide so
// saturation is reachable with a few hits.
// -----------------------------------------------------------------------------
module tb_netwalk_tcam_pipe;
    import netwalk_tcam_pkg::*;

    localparam int KW   = 356;
    localparam int AW   = 6;
    localparam int TW   = 5;
    localparam int SIZE = 1 << AW;
`ifdef NETWALK_TCAM_HIT_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 32;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cnt_rd_addr;
    logic [CW-1:0] cnt_rd_data;

    netwalk_tcam_pipe_if #(.KEY_WIDTH(KW), .TCAM_ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    netwalk_tcam_pipe #(
        .KEY_WIDTH(KW), .TCAM_ADDR_WIDTH(AW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .cnt_rd_addr (cnt_rd_addr),
        .cnt_rd_data (cnt_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          hit;
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
    } rsp_t;

    logic [SIZE-1:0] m_valid;
    logic [KW-1:0]   m_data [SIZE];
    logic [KW-1:0]   m_mask [SIZE];
    longint          m_cnt  [SIZE];
    longint          cnt_max = (64'd1 << CW) - 1;
    rsp_t            exp_q [$];

    int   n_acc  = 0;
    int   n_rsp  = 0;
    int   n_hits = 0;
    rsp_t last_rsp;

    function automatic rsp_t model_lookup(input logic [KW-1:0] key, input logic [TW-1:0] tag);
        rsp_t r;
        r.hit  = 1'b0;
        r.addr = '0;
        r.tag  = tag;
        for (int i = 0; i < SIZE; i++) begin
            if (!r.hit && m_valid[i] && (((key ^ m_data[i]) & m_mask[i]) == '0)) begin
                r.hit  = 1'b1;
                r.addr = AW'(i);
            end
        end
        return r;
    endfunction

    // ---------------- monitor / compare ----------------
    rsp_t held;
    logic held_v = 1'b0;

    always @(negedge clk) begin
        rsp_t cur;
        rsp_t want;
        int   a;
        cur = {bus.rsp_hit, bus.rsp_addr, bus.rsp_tag};
        if (held_v) begin
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_rsp", 64'(cur), 64'(held));
        end
        held_v = 1'b0;
        if (!reset) begin
            exp_q.delete();
            m_valid = '0;
            for (int i = 0; i < SIZE; i++) m_cnt[i] = 0;
        end else begin
            held_v = bus.rsp_valid && !bus.rsp_ready;
            held   = cur;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got %0h, expected no response", cur);
                end else begin
                    want = exp_q.pop_front();
                    check("rsp_hit", 64'(cur.hit), 64'(want.hit));
                    check("rsp_addr", 64'(cur.addr), 64'(want.addr));
                    check("rsp_tag", 64'(cur.tag), 64'(want.tag));
                end
                last_rsp = cur;
                n_rsp++;
                if (cur.hit) begin
                    n_hits++;
                    if (m_cnt[cur.addr] < cnt_max) m_cnt[cur.addr]++;
                end
            end
            if (bus.lkp_valid && bus.lkp_ready) begin
                exp_q.push_back(model_lookup(bus.lkp_key, bus.lkp_tag));
                n_acc++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                a = int'(bus.cmd_addr);
                case (bus.cmd_op)
                    2'b00: begin
                        m_valid[a] = 1'b1;
                        m_data[a]  = bus.cmd_data;
                        m_mask[a]  = bus.cmd_mask;
                        m_cnt[a]   = 0;
                    end
                    2'b01: begin
                        m_valid[a] = 1'b0;
                        m_cnt[a]   = 0;
                    end
                    2'b10: begin
                        m_valid = '0;
                        for (int i = 0; i < SIZE; i++) m_cnt[i] = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [KW-1:0] rand_key();
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < 12; i++) k = {k[KW-33:0], 32'($urandom)};
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input int op, input int addr, input logic [KW-1:0] data,
                          input logic [KW-1:0] mask);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op[1:0];
        bus.cmd_addr  = addr[AW-1:0];
        bus.cmd_data  = data;
        bus.cmd_mask  = mask;
        @(negedge clk);
        check("cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_lkp(input logic [KW-1:0] key, input logic [TW-1:0] tag);
        int waited = 0;
        bus.lkp_valid = 1'b1;
        bus.lkp_key   = key;
        bus.lkp_tag   = tag;
        @(negedge clk);
        while (!bus.lkp_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL lkp_timeout: lkp_ready low for %0d cycles, expected accept", waited);
        end
        tick();
        bus.lkp_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        bus.rsp_ready = 1'b1;
        while (exp_q.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        tick();
        tick();
    endtask

    // ---------------- main sequence ----------------
    logic [KW-1:0] all1;
    logic [KW-1:0] k_a, k_b, k_c;
    int            acc0, rsp0, hits0, lat;

    initial begin
        all1 = '1;
        for (int i = 0; i < SIZE; i++) begin
            m_data[i] = '0;
            m_mask[i] = '0;
            m_cnt[i]  = 0;
        end
        reset         = 1'b0;
        cnt_rd_addr   = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_mask  = '0;
        bus.rsp_ready = 1'b1;
        bus.lkp_valid = 1'b1;             // lookups offered during reset must vanish
        bus.lkp_key   = rand_key();
        bus.lkp_tag   = 5'd7;

        // Reset: two cycles low with a lookup pending.
        repeat (2) begin
            @(negedge clk);
            check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end
        check("rst_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        check("rst_rsp_addr", 64'(bus.rsp_addr), 64'd0);
        check("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        tick();
        reset         = 1'b1;
        bus.lkp_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", 64'(bus.rsp_valid), 64'd0);
        end
        tick();

        // First lookup after reset misses.
        rsp0 = n_rsp;
        do_lkp(rand_key(), 5'd1);
        drain();
        check("post_rst_rsp_cnt", 64'(n_rsp - rsp0), 64'd1);
        check("post_rst_hit", 64'(last_rsp.hit), 64'd0);
        check("post_rst_addr", 64'(last_rsp.addr), 64'd0);

        // Exact match on idx5 with latency measured from the presenting cycle.
        k_a = rand_key();
        do_cmd(0, 5, k_a, all1);
        bus.lkp_valid = 1'b1;
        bus.lkp_key   = k_a;
        bus.lkp_tag   = 5'd3;
        @(negedge clk);
        check("lat_lkp_ready", 64'(bus.lkp_ready), 64'd1);
        tick();
        bus.lkp_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            tick();
            lat++;
        end
        check("latency_edges", 64'(lat), 64'd2);
        check("exact_hit", 64'(bus.rsp_hit), 64'd1);
        check("exact_addr", 64'(bus.rsp_addr), 64'd5);
        check("exact_tag", 64'(bus.rsp_tag), 64'd3);
        drain();
        do_lkp(k_a ^ KW'(1), 5'd4);
        drain();
        check("near_miss_hit", 64'(last_rsp.hit), 64'd0);
        check("near_miss_addr", 64'(last_rsp.addr), 64'd0);
        check("near_miss_tag", 64'(last_rsp.tag), 64'd4);

        // Top index is writable.
        k_b = rand_key();
        do_cmd(0, SIZE - 1, k_b, all1);
        do_lkp(k_b, 5'd6);
        drain();
        check("top_idx_hit", 64'(last_rsp.hit), 64'd1);
        check("top_idx_addr", 64'(last_rsp.addr), 64'(SIZE - 1));

        // Wildcards and priority.
        do_cmd(0, 9, rand_key(), '0);
        do_cmd(0, 2, rand_key(), '0);
        do_lkp(rand_key(), 5'd8);
        drain();
        check("prio_addr_2", 64'(last_rsp.addr), 64'd2);
        do_cmd(1, 2, '0, '0);
        do_lkp(rand_key(), 5'd9);
        drain();
        check("prio_addr_9", 64'(last_rsp.addr), 64'd9);
        do_cmd(1, 2, '0, '0);                 // entry already invalid
        do_lkp(k_a, 5'd10);
        drain();
        check("del_invalid_addr", 64'(last_rsp.addr), 64'd5);
        check("del_invalid_hit", 64'(last_rsp.hit), 64'd1);

        // Backpressure: 4 back-to-back lookups, response stalled 6 cycles.
        do_cmd(2, 0, '0, '0);
        do_cmd(0, 5, k_a, all1);
        acc0 = n_acc;
        rsp0 = n_rsp;
        bus.rsp_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) do_lkp((i % 2 == 1) ? k_a : rand_key(), TW'(12 + i));
            end
            begin
                repeat (6) @(negedge clk);
                check("bp_accepts", 64'(n_acc - acc0), 64'd2);
                check("bp_lkp_ready", 64'(bus.lkp_ready), 64'd0);
                tick();
                bus.rsp_ready = 1'b1;
            end
        join
        drain();
        check("bp_rsp_count", 64'(n_rsp - rsp0), 64'd4);
        check("bp_last_tag", 64'(last_rsp.tag), 64'd15);
        check("bp_last_addr", 64'(last_rsp.addr), 64'd5);

        // Command/lookup collision: command wins, lookup then sees new entry.
        do_cmd(2, 0, '0, '0);
        k_c = rand_key();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 6'd20;
        bus.cmd_data  = k_c;
        bus.cmd_mask  = all1;
        bus.lkp_valid = 1'b1;
        bus.lkp_key   = k_c;
        bus.lkp_tag   = 5'd9;
        @(negedge clk);
        check("coll_lkp_ready", 64'(bus.lkp_ready), 64'd0);
        tick();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("coll_lkp_ready_next", 64'(bus.lkp_ready), 64'd1);
        tick();
        bus.lkp_valid = 1'b0;
        drain();
        check("coll_hit", 64'(last_rsp.hit), 64'd1);
        check("coll_addr", 64'(last_rsp.addr), 64'd20);
        check("coll_tag", 64'(last_rsp.tag), 64'd9);

        // FLUSH mid-stream: three lookups before, three after.
        hits0 = n_hits;
        for (int i = 0; i < 3; i++) do_lkp(k_c, TW'(i));
        do_cmd(2, 0, '0, '0);
        for (int i = 0; i < 3; i++) do_lkp(k_c, TW'(3 + i));
        drain();
        check("flush_hits", 64'(n_hits - hits0), 64'd3);
        check("flush_last_hit", 64'(last_rsp.hit), 64'd0);

        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            int r, idx;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.cmd_valid = ($urandom_range(0, 5) == 0);
            r = int'($urandom_range(0, 39));
            bus.cmd_op    = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r < 12) ? 2'b01 : 2'b00;
            bus.cmd_addr  = ($urandom_range(0, 9) == 0) ? AW'(SIZE - 1) : AW'($urandom_range(0, 15));
            bus.cmd_data  = rand_key();
            r = int'($urandom_range(0, 9));
            bus.cmd_mask  = (r == 0) ? '0 : (r < 6) ? all1 : rand_key();
            bus.lkp_valid = ($urandom_range(0, 2) != 0);
            idx = ($urandom_range(0, 9) == 0) ? SIZE - 1 : int'($urandom_range(0, 15));
            bus.lkp_key   = ($urandom_range(0, 3) == 0) ? rand_key()
                                                        : (m_data[idx] ^ (rand_key() & ~m_mask[idx]));
            bus.lkp_tag   = TW'($urandom);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.lkp_valid = 1'b0;
        drain();

`ifdef NETWALK_TCAM_HIT_CNT_EN
        for (int i = 0; i < SIZE; i++) begin
            cnt_rd_addr = AW'(i);
            @(negedge clk);
            check("cnt_random", 64'(cnt_rd_data), 64'(m_cnt[i]));
        end
        tick();
        do_cmd(2, 0, '0, '0);
        do_cmd(0, 5, k_a, all1);
        cnt_rd_addr = 6'd5;
        for (int i = 0; i < 3; i++) do_lkp(k_a, TW'(i));
        drain();
        check("cnt_three_hits", 64'(cnt_rd_data), 64'd3);
        do_lkp(k_a, 5'd3);
        drain();
        check("cnt_saturated", 64'(cnt_rd_data), 64'd3);
        do_cmd(0, 5, k_a, all1);
        @(negedge clk);
        check("cnt_write_clear", 64'(cnt_rd_data), 64'd0);
        tick();
`else
        cnt_rd_addr = 6'd5;
        @(negedge clk);
        check("cnt_tied_zero", 64'(cnt_rd_data), 64'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
